pif_flasher_multi: RTL and testbench

- Parametrised multi-channel LED flasher, successor to the two-colour PIF status flasher.
- Drives CHANNELS active-low LED outputs. Each channel has its own mode: off, on, blink or breathe.
- One shared tick prescaler and one shared brightness ramp serve all channels. Each channel has its own first-order sigma-delta PWM.
- Sits beside the board oscillator; host logic configures channels through a single-cycle write port.

---
 rtl/pif_flasher_multi.sv | 117 +++++++++++
 tb/tb_pif_flasher_multi.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pif_flasher_multi.sv
// Multi-channel active-low LED flasher (off/on/blink/breathe); PIF_FLASH_GAMMA_EN squares the breathe ramp.
// Latency: tick edge to first affected led_n is 2 cycles; no backpressure, the config port accepts every write.
module pif_flasher_multi #(
    parameter int CHANNELS = 4,
    parameter int CHW      = 2,
    parameter int B        = 5,
    parameter int TICK_DIV = 177333,
    parameter int DIVW     = 18
) (
    input  logic                osc,
    input  logic                sys_rst,
    input  logic                cfg_we,
    input  logic [CHW-1:0]      cfg_ch,
    input  logic [1:0]          cfg_mode,
    input  logic [B-1:0]        cfg_level,
    output logic [CHANNELS-1:0] led_n,
    output logic                tick
);

    typedef enum logic [1:0] {
        MODE_OFF     = 2'd0,
        MODE_ON      = 2'd1,
        MODE_BLINK   = 2'd2,
        MODE_BREATHE = 2'd3
    } mode_e;

    localparam logic [DIVW-1:0] RELOAD = DIVW'(TICK_DIV - 1);

    logic [DIVW-1:0]     presc_q;
    logic                tick_q;
    logic [B:0]          rc_q;
    mode_e               mode_q    [CHANNELS];
    logic [B-1:0]        level_q   [CHANNELS];
    logic [B-1:0]        duty_sh_q [CHANNELS];
    logic [B:0]          acc_q     [CHANNELS];
    logic [CHANNELS-1:0] led_n_q;

    logic [B-1:0]        tri_w;
    logic [B-1:0]        breathe_w;
    logic [B-1:0]        duty_d    [CHANNELS];

    // Triangle: up-count in the first half of the ramp, mirrored in the second.
    always_comb begin
        tri_w = rc_q[B] ? ~rc_q[B-1:0] : rc_q[B-1:0];
    end

`ifdef PIF_FLASH_GAMMA_EN
    logic [2*B-1:0] tri_sq;
    always_comb begin
        tri_sq    = {{B{1'b0}}, tri_w} * {{B{1'b0}}, tri_w};
        breathe_w = B'(tri_sq >> B);
    end
`else
    always_comb begin
        breathe_w = tri_w;
    end
`endif

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            duty_d[i] = '0;
            case (mode_q[i])
                MODE_OFF:     duty_d[i] = '0;
                MODE_ON:      duty_d[i] = level_q[i];
                MODE_BLINK:   duty_d[i] = rc_q[B] ? '0 : level_q[i];
                MODE_BREATHE: duty_d[i] = breathe_w;
                default:      duty_d[i] = '0;
            endcase
        end
    end

    always_ff @(posedge osc) begin
        if (sys_rst) begin
            presc_q <= RELOAD;
            tick_q  <= 1'b0;
            rc_q    <= '0;
            led_n_q <= '1;
            for (int i = 0; i < CHANNELS; i++) begin
                mode_q[i]    <= MODE_OFF;
                level_q[i]   <= '0;
                duty_sh_q[i] <= '0;
                acc_q[i]     <= '0;
            end
        end else begin
            if (presc_q == '0) begin
                presc_q <= RELOAD;
                tick_q  <= 1'b1;
            end else begin
                presc_q <= presc_q - 1'b1;
                tick_q  <= 1'b0;
            end

            if (tick_q) begin
                rc_q <= rc_q + 1'b1;
            end

            // Shadow and accumulator restart together so every window starts clean.
            for (int i = 0; i < CHANNELS; i++) begin
                if (tick_q) begin
                    duty_sh_q[i] <= duty_d[i];
                    acc_q[i]     <= '0;
                end else begin
                    acc_q[i] <= {1'b0, acc_q[i][B-1:0]} + {1'b0, duty_sh_q[i]};
                end
                led_n_q[i] <= ~acc_q[i][B];
                if (cfg_we && (cfg_ch == CHW'(i))) begin
                    mode_q[i]  <= mode_e'(cfg_mode);
                    level_q[i] <= cfg_level;
                end
            end
        end
    end

    assign led_n = led_n_q;
    assign tick  = tick_q;

endmodule

// File: tb/tb_pif_flasher_multi.sv
module tb_pif_flasher_multi;

    localparam int CH   = 4;
    localparam int CHW  = 3;
    localparam int B    = 3;
    localparam int TD   = 9;
    localparam int DIVW = 4;
    localparam int NW   = 1 << B;

    logic          osc = 1'b0;
    logic          sys_rst;
    logic          cfg_we;
    logic [CHW-1:0] cfg_ch;
    logic [1:0]    cfg_mode;
    logic [B-1:0]  cfg_level;
    logic [CH-1:0] led_n;
    logic          tick;

    always #5 osc = ~osc;

    pif_flasher_multi #(
        .CHANNELS(CH), .CHW(CHW), .B(B), .TICK_DIV(TD), .DIVW(DIVW)
    ) dut (
        .osc(osc), .sys_rst(sys_rst), .cfg_we(cfg_we), .cfg_ch(cfg_ch),
        .cfg_mode(cfg_mode), .cfg_level(cfg_level), .led_n(led_n), .tick(tick)
    );

    int checks = 0;
    int errors = 0;

    // Reference state: n counts cycles since the last reset edge.
    int m_mode  [CH];
    int m_level [CH];
    int rc;
    int n;
    bit have_rst = 1'b0;
    bit win_open = 1'b0;
    int exp_next [CH];
    int exp_cur  [CH];
    int cnt      [CH];

    function automatic int duty_of(input int mode, input int lvl, input int r);
        int t;
        t = (r < NW) ? r : (2 * NW - 1 - r);
        case (mode)
            0: return 0;
            1: return lvl;
            2: return (r < NW) ? lvl : 0;
            default: begin
`ifdef PIF_FLASH_GAMMA_EN
                return (t * t) / NW;
`else
                return t;
`endif
            end
        endcase
    endfunction

    function automatic bit exp_tick(input int nn);
        return (nn > 0) && (nn % TD == 0);
    endfunction

    task automatic model_edge();
        if (sys_rst) begin
            n = 0;
            rc = 0;
            win_open = 1'b0;
            have_rst = 1'b1;
            for (int i = 0; i < CH; i++) begin
                m_mode[i] = 0;
                m_level[i] = 0;
                exp_next[i] = 0;
            end
        end else if (have_rst) begin
            if (exp_tick(n)) begin
                for (int i = 0; i < CH; i++) exp_next[i] = duty_of(m_mode[i], m_level[i], rc);
                rc = (rc + 1) % (2 * NW);
            end
            if (cfg_we && (int'(cfg_ch) < CH)) begin
                m_mode[cfg_ch]  = int'(cfg_mode);
                m_level[cfg_ch] = int'(cfg_level);
            end
            n++;
        end
    endtask

    task automatic monitor();
        if (!have_rst) return;
        checks++;
        assert (tick === exp_tick(n)) else begin
            errors++;
            $error("FAIL tick n=%0d observed=%b expected=%b", n, tick, exp_tick(n));
        end
        // A window spans the 2^B+1 cycles starting three cycles after a tick.
        if (n >= TD + 3 && (n - 3) % TD == 0) begin
            if (win_open) begin
                for (int i = 0; i < CH; i++) begin
                    checks++;
                    assert (cnt[i] === exp_cur[i]) else begin
                        errors++;
                        $error("FAIL on_count ch%0d n=%0d observed=%0d expected=%0d", i, n, cnt[i], exp_cur[i]);
                    end
                end
            end
            for (int i = 0; i < CH; i++) begin
                exp_cur[i] = exp_next[i];
                cnt[i] = 0;
            end
            win_open = 1'b1;
        end
        if (win_open) begin
            for (int i = 0; i < CH; i++) if (led_n[i] === 1'b0) cnt[i]++;
        end else begin
            checks++;
            assert (led_n === 4'b1111) else begin
                errors++;
                $error("FAIL led_idle n=%0d observed=%b expected=1111", n, led_n);
            end
        end
    endtask

    task automatic step();
        @(negedge osc);
        model_edge();
        monitor();
    endtask

    task automatic run(input int k);
        repeat (k) step();
    endtask

    task automatic wr(input int ch, input int mode, input int lvl);
        cfg_we    = 1'b1;
        cfg_ch    = CHW'(ch);
        cfg_mode  = 2'(mode);
        cfg_level = B'(lvl);
        step();
        cfg_we    = 1'b0;
    endtask

    task automatic pulse_rst();
        sys_rst = 1'b1;
        step();
        sys_rst = 1'b0;
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        step();
        while (tick !== 1'b1 && k < 2 * TD) begin
            step();
            k++;
        end
        checks++;
        assert (tick === 1'b1) else begin
            errors++;
            $error("FAIL wait_tick observed=%b expected=1 within %0d cycles", tick, 2 * TD);
        end
    endtask

    initial begin
        sys_rst   = 1'b1;
        cfg_we    = 1'b0;
        cfg_ch    = '0;
        cfg_mode  = '0;
        cfg_level = '0;
        run(2);
        sys_rst = 1'b0;
        run(40);

        wr(0, 1, 4);
        run(30);

        wr(1, 1, 0);
        wr(2, 1, 7);
        run(27);
        wr(5, 1, 3);
        run(27);

        wr(3, 3, 0);
        run(16 * TD + 20);

        wait_tick();
        wr(0, 2, 5);
        run(16 * TD + 10);

        run(23);
        pulse_rst();
        run(40);

        wr(3, 3, 0);
        wr(1, 2, 6);
        run(5);
        wait_tick();
        pulse_rst();
        run(30);

        repeat (400) begin
            if ($urandom_range(0, 149) == 0) pulse_rst();
            else if ($urandom_range(0, 3) == 0)
                wr($urandom_range(0, 7), $urandom_range(0, 3), $urandom_range(0, NW - 1));
            else step();
        end

        for (int i = 0; i < CH; i++) wr(i, $urandom_range(0, 3), $urandom_range(0, NW - 1));
        run(16 * TD + 20);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
